// File: rtl/shift_seq_pkg.sv
// Shared constants for the iterative shift sequencer: state encoding, op codes, widths.
// Used by shift_seq_ctrl and shift_step (SHIFT_STRIDE4_EN selects the 4-step variant there).
package shift_seq_pkg;

  localparam int DW = 32;
  localparam int SW = 5;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // Reserved code 2'b11 falls through to a left shift.
  function automatic logic is_right(input logic [1:0] op);
    return (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift step (by 1, or by 4 when stride4 is set) for the shift sequencer.
// Macro SHIFT_STRIDE4_EN builds the 4-position path; otherwise only the 1-position path exists.
module shift_step
  import shift_seq_pkg::*;
(
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    op,
  input  logic          stride4,
  output logic [DW-1:0] data_out
);

  logic          right;
  logic          fill;
  logic [DW-1:0] sh1;

  assign right = is_right(op);
  assign fill  = (op == OP_SRA) & data_in[DW-1];

  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_sh1
      logic l1;
      logic r1;
      if (gi >= 1) begin : g_l
        assign l1 = data_in[gi-1];
      end else begin : g_l0
        assign l1 = 1'b0;
      end
      if (gi <= DW - 2) begin : g_r
        assign r1 = data_in[gi+1];
      end else begin : g_rf
        assign r1 = fill;
      end
      assign sh1[gi] = right ? r1 : l1;
    end
  endgenerate

`ifdef SHIFT_STRIDE4_EN
  logic [DW-1:0] sh4;

  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_sh4
      logic l4;
      logic r4;
      if (gi >= 4) begin : g_l
        assign l4 = data_in[gi-4];
      end else begin : g_l0
        assign l4 = 1'b0;
      end
      if (gi <= DW - 5) begin : g_r
        assign r4 = data_in[gi+4];
      end else begin : g_rf
        assign r4 = fill;
      end
      assign sh4[gi] = right ? r4 : l4;
    end
  endgenerate

  assign data_out = stride4 ? sh4 : sh1;
`else
  logic stride4_unused;
  assign stride4_unused = stride4;
  assign data_out       = sh1;
`endif

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer for the EX stage: FSM, remaining-count and result register.
// Define SHIFT_STRIDE4_EN to step by 4 positions while at least 4 remain.
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] shamt,
  input  logic [DW-1:0] src,
  input  logic          flush,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  state_t        state_reg, state_next;
  logic [SW-1:0] cnt_reg, cnt_next;
  logic [1:0]    op_reg, op_next;
  logic [DW-1:0] result_reg, result_next;

  logic [SW-1:0] amt;
  logic          shamt_unused;
  logic          stride4;
  logic [SW-1:0] step;
  logic [DW-1:0] step_out;

  assign amt          = shamt[SW-1:0];
  assign shamt_unused = ^shamt[DW-1:SW];

`ifdef SHIFT_STRIDE4_EN
  assign stride4 = (cnt_reg >= SW'(4));
`else
  assign stride4 = 1'b0;
`endif
  assign step = stride4 ? SW'(4) : SW'(1);

  shift_step u_step (
    .data_in  (result_reg),
    .op       (op_reg),
    .stride4  (stride4),
    .data_out (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      op_reg     <= OP_SLL;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    result_next = result_reg;
    busy        = 1'b0;

    // A flush wins over everything, including a same-cycle start.
    if (flush) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_SHIFT: begin
          busy        = 1'b1;
          result_next = step_out;
          cnt_next    = cnt_reg - step;
          if (cnt_next == '0) begin
            state_next = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          state_next = ST_IDLE;
          if (start) begin
            op_next     = op;
            result_next = src;
            if (amt == '0) begin
              state_next = ST_DONE;
            end else begin
              cnt_next   = amt;
              state_next = ST_SHIFT;
              busy       = 1'b1;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign done   = (state_reg == ST_DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: cycle-level reference model plus directed literal checks.
// Expected cycle counts follow SHIFT_STRIDE4_EN when it is defined for the build.
module tb_shift_seq_ctrl;

`ifdef SHIFT_STRIDE4_EN
  localparam bit STRIDE = 1'b1;
`else
  localparam bit STRIDE = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] shamt;
  logic [31:0] src;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  shift_seq_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .shamt  (shamt),
    .src    (src),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is described by its operand, kind, total amount
  // and how many positions have been applied so far.
  function automatic logic [31:0] shifted(input logic [31:0] v, input logic [1:0] o, input int p);
    case (o)
      2'b01:   return v >> p;
      2'b10:   return 32'($signed(v) >>> p);
      default: return v << p;
    endcase
  endfunction

  function automatic int next_pos(input int n, input int p);
    if (STRIDE && (n - p) >= 4) return p + 4;
    return p + 1;
  endfunction

  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_src  = '0;
  logic [1:0]  m_op   = '0;
  int          m_n    = 0;
  int          m_p    = 0;
  logic        exp_busy;

  assign exp_busy = !flush && (m_busy || (start && shamt[4:0] != 5'd0));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= '0;
      m_p    <= 0;
      m_n    <= 0;
    end else if (flush) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_p    <= next_pos(m_n, m_p);
      m_res  <= shifted(m_src, m_op, next_pos(m_n, m_p));
      m_done <= (next_pos(m_n, m_p) == m_n);
      m_busy <= (next_pos(m_n, m_p) != m_n);
    end else begin
      m_done <= start && (shamt[4:0] == 5'd0);
      m_busy <= start && (shamt[4:0] != 5'd0);
      if (start) begin
        m_src <= src;
        m_op  <= op;
        m_n   <= int'(shamt[4:0]);
        m_p   <= 0;
        m_res <= src;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model done", {31'd0, done}, {31'd0, m_done});
      chk("model busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("model result", result, m_res);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after done.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] s, input int exp_lat, input int exp_bc,
                        input logic [31:0] exp_res);
    int          lat = -1;
    int          bc  = 0;
    logic [31:0] r   = '0;
    start = 1'b1;
    op    = o;
    shamt = a;
    src   = s;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        lat = k;
        r   = result;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy cycles"}, 32'(bc), 32'(exp_bc));
    chk({nm, " result"}, r, exp_res);
    $display("txn %s: op=%0d shamt=%h src=%h -> result=%h latency=%0d busy=%0d",
             nm, o, a, s, r, lat, bc);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    shamt = '0;
    src   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    $display("txn reset: done=%0d busy=%0d result=%h", done, busy, result);
    @(posedge clk);
    #1;

    run_op("sll5", 2'b00, 32'd5, 32'h0000_0001, STRIDE ? 3 : 6, STRIDE ? 3 : 6, 32'h0000_0020);
    run_op("sra31", 2'b10, 32'd31, 32'h8000_0000, STRIDE ? 11 : 32, STRIDE ? 11 : 32, 32'hFFFF_FFFF);
    run_op("zero", 2'b00, 32'h0000_0020, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF);
    run_op("sra_pos", 2'b10, 32'd3, 32'h7000_0000, 4, 4, 32'h0E00_0000);
    run_op("reserved", 2'b11, 32'd2, 32'h0000_0003, 3, 3, 32'h0000_000C);
    run_op("srl_hi_ign", 2'b01, 32'h0000_0101, 32'h8000_0001, 2, 2, 32'h4000_0000);

    // Back-to-back: second start presented in the DONE cycle of the first.
    l     = STRIDE ? 2 : 5;
    start = 1'b1;
    op    = 2'b01;
    shamt = 32'd4;
    src   = 32'hF000_0000;
    for (int c = 0; c <= l + 2; c++) begin
      @(negedge clk);
      if (c == l) begin
        chk("b2b first done", {31'd0, done}, 32'd1);
        chk("b2b first result", result, 32'h0F00_0000);
        chk("b2b busy at restart", {31'd0, busy}, 32'd1);
      end
      if (c == l + 1) chk("b2b no idle gap", {31'd0, busy}, 32'd1);
      if (c == l + 2) begin
        chk("b2b second done", {31'd0, done}, 32'd1);
        chk("b2b second result", result, 32'h0000_0002);
      end
      @(posedge clk);
      #1;
      if (c == l - 1) begin
        start = 1'b1;
        op    = 2'b00;
        shamt = 32'd1;
        src   = 32'h0000_0001;
      end else begin
        start = 1'b0;
      end
    end
    $display("txn b2b: srl F0000000>>4 then sll 1<<1, final result=%h", result);

    // Flush in the third SHIFT cycle of a 10-position shift.
    start = 1'b1;
    op    = 2'b00;
    shamt = 32'd10;
    src   = 32'h0000_0001;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 3) chk("flush busy low", {31'd0, busy}, 32'd0);
      if (c >= 3) chk("flush no done", {31'd0, done}, 32'd0);
      if (c == 4) chk("flush result held", result, STRIDE ? 32'h0000_0100 : 32'h0000_0004);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = (c == 2);
    end
    $display("txn flush: aborted sll by 10, held result=%h", result);
    run_op("after_flush", 2'b01, 32'd3, 32'h0000_0080, 4, 4, 32'h0000_0010);

    // Reset mid-SHIFT, with start held (and ignored) during SHIFT.
    start = 1'b1;
    op    = 2'b00;
    shamt = 32'd20;
    src   = 32'h0000_0001;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        chk("held start ignored", result, STRIDE ? 32'h0000_0100 : 32'h0000_0004);
        chk("held start busy", {31'd0, busy}, 32'd1);
      end
      @(posedge clk);
      #1;
      op    = 2'b10;
      shamt = 32'd7;
      src   = 32'hAAAA_AAAA;
    end
    rst_n = 1'b0;
    start = 1'b0;
    #2;
    chk("async reset result", result, 32'd0);
    chk("async reset busy", {31'd0, busy}, 32'd0);
    chk("async reset done", {31'd0, done}, 32'd0);
    $display("txn async_reset: result=%h busy=%0d done=%0d", result, busy, done);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post reset done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    run_op("post_reset", 2'b00, 32'd1, 32'h0000_0001, 2, 2, 32'h0000_0002);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
